// File: rtl/renode_pkg.sv
// Shared Renode co-simulation types and helpers.
// Message layout matches what the sender forwards to the async receiver.
package renode_pkg;

    typedef logic [63:0] address_t;
    typedef logic [63:0] data_t;

    typedef enum int unsigned {
        invalid_action = 0,
        tick_clock,
        write_request,
        read_request,
        ok,
        error,
        interrupt
    } action_t;

    typedef struct packed {
        action_t  action;
        address_t address;
        data_t    data;
    } message_t;

    // Index width for N interrupt lines; never narrower than one bit.
    function automatic int IrqIdxWidth(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic message_t irq_message(
        input address_t idx,
        input logic     level
    );
        message_t m;
        m.action  = interrupt;
        m.address = idx;
        m.data    = data_t'(level);
        return m;
    endfunction

endpackage

// File: rtl/renode_interrupts_arbiter_if.sv
// Valid/ready port carrying one {index, level} interrupt message.
// The arbiter is master; the Renode sender is slave.
interface renode_interrupts_arbiter_if #(
    parameter int AddrWidth = 5
);

    logic                 msg_valid;
    logic                 msg_ready;
    logic [AddrWidth-1:0] msg_addr;
    logic                 msg_level;

    modport master (
        output msg_valid,
        output msg_addr,
        output msg_level,
        input  msg_ready
    );

    modport slave (
        input  msg_valid,
        input  msg_addr,
        input  msg_level,
        output msg_ready
    );

endinterface

// File: rtl/renode_interrupts_debounce.sv
// One interrupt line: optional synchroniser chain followed by a
// persistence filter that only accepts changes lasting StableCycles.
module renode_interrupts_debounce #(
    parameter int SyncStages   = 2,
    parameter int StableCycles = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    output logic filtered
);

    localparam int CW = (StableCycles < 2) ? 1 : $clog2(StableCycles);

    logic          synced;
    logic [CW-1:0] cnt;

    if (SyncStages == 0) begin : g_nosync
        assign synced = irq;
    end else begin : g_sync
        logic [SyncStages-1:0] chain;

        always_ff @(posedge clk) begin
            if (rst) begin
                chain <= '0;
            end else begin
                chain <= SyncStages'({chain, irq});
            end
        end

        assign synced = chain[SyncStages-1];
    end

    // cnt counts how long synced has disagreed with filtered
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            filtered <= 1'b0;
        end else if (synced == filtered) begin
            cnt <= '0;
        end else if (cnt == CW'(StableCycles - 1)) begin
            filtered <= synced;
            cnt      <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/renode_interrupts_arbiter.sv
// Interrupt-change reporter: debounced lines, masked pending set,
// round-robin selection onto a single valid/ready message port.
module renode_interrupts_arbiter
    import renode_pkg::*;
#(
    parameter int InterruptsCount = 32,
    parameter int SyncStages      = 2,
    parameter int StableCycles    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [InterruptsCount-1:0] interrupts,
    input  logic [InterruptsCount-1:0] mask,
    output logic                       busy,
    renode_interrupts_arbiter_if.master msg
);

    localparam int N  = InterruptsCount;
    localparam int AW = IrqIdxWidth(N);
    localparam int SW = AW + 1;

    logic [N-1:0]  filtered;
    logic [N-1:0]  reported;
    logic [N-1:0]  pending;
    logic [N-1:0]  cand;
    logic [N-1:0]  rot;
    logic [AW-1:0] rr_ptr;
    logic [AW-1:0] off;
    logic [AW-1:0] pick;
    logic [SW-1:0] sum;
    logic          found;
    logic          hs;
    logic          load;
    logic          valid_q;
    logic [AW-1:0] addr_q;
    logic          level_q;

    for (genvar i = 0; i < N; i++) begin : g_line
        renode_interrupts_debounce #(
            .SyncStages  (SyncStages),
            .StableCycles(StableCycles)
        ) u_db (
            .clk     (clk),
            .rst     (rst),
            .irq     (interrupts[i]),
            .filtered(filtered[i])
        );
    end

    assign pending = (filtered ^ reported) & ~mask;
    assign hs      = valid_q && msg.msg_ready;
    assign load    = !valid_q || msg.msg_ready;
    assign busy    = |pending | valid_q;

    // The line being accepted this cycle is not yet settled in reported
    always_comb begin
        cand = pending;
        if (hs) begin
            cand[addr_q] = 1'b0;
        end
    end

    assign rot = N'({cand, cand} >> rr_ptr);

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = AW'(i);
            end
        end
        sum = {1'b0, off} + {1'b0, rr_ptr};
        if (sum >= SW'(N)) begin
            sum = sum - SW'(N);
        end
        pick = sum[AW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reported <= '0;
            rr_ptr   <= '0;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            level_q  <= 1'b0;
        end else begin
            if (hs) begin
                reported[addr_q] <= level_q;
            end
            if (load) begin
                valid_q <= found;
                if (found) begin
                    addr_q  <= pick;
                    level_q <= filtered[pick];
                    rr_ptr  <= (pick == AW'(N - 1)) ? '0 : pick + AW'(1);
                end
            end
        end
    end

    assign msg.msg_valid = valid_q;
    assign msg.msg_addr  = addr_q;
    assign msg.msg_level = level_q;

endmodule

// File: tb/tb_renode_interrupts_arbiter.sv
// Bench for renode_interrupts_arbiter: two instances (StableCycles 1 and 4)
// share stimulus and are compared every cycle against a behavioural model.
module tb_renode_interrupts_arbiter;

    localparam int N  = 16;
    localparam int SS = 2;

    typedef struct {
        int g;
        int a;
        int l;
        int c;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq;
    logic [N-1:0] msk;
    logic         rdy;
    logic         busy0;
    logic         busy1;
    logic         dv[2];
    logic         dl[2];
    logic         db[2];
    logic [3:0]   da[2];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    ev_t evq[$];

    bit [N-1:0] filt[2];
    bit [N-1:0] rep[2];
    bit [N-1:0] hist[2][SS];
    int         run[2][N];
    bit         mv[2];
    bit         ml[2];
    int         ma[2];
    int         ptr[2];

    always #5 clk = ~clk;

    renode_interrupts_arbiter_if #(.AddrWidth(4)) if0 ();
    renode_interrupts_arbiter_if #(.AddrWidth(4)) if1 ();

    assign if0.msg_ready = rdy;
    assign if1.msg_ready = rdy;
    assign dv[0] = if0.msg_valid;
    assign dv[1] = if1.msg_valid;
    assign da[0] = if0.msg_addr;
    assign da[1] = if1.msg_addr;
    assign dl[0] = if0.msg_level;
    assign dl[1] = if1.msg_level;
    assign db[0] = busy0;
    assign db[1] = busy1;

    renode_interrupts_arbiter #(
        .InterruptsCount(N),
        .SyncStages     (SS),
        .StableCycles   (1)
    ) dut0 (
        .clk       (clk),
        .rst       (rst),
        .interrupts(irq),
        .mask      (msk),
        .busy      (busy0),
        .msg       (if0)
    );

    renode_interrupts_arbiter #(
        .InterruptsCount(N),
        .SyncStages     (SS),
        .StableCycles   (4)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .interrupts(irq),
        .mask      (msk),
        .busy      (busy1),
        .msg       (if1)
    );

    function automatic int stab(input int g);
        return (g == 0) ? 1 : 4;
    endfunction

    task automatic chk(
        input string       nm,
        input int          g,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h",
                     nm, g, act, exp);
        end
    endtask

    // Model: delayed raw input, persistence filter, cyclic search
    // for the next line whose filtered level differs from what was sent.
    task automatic m_update(input int g);
        bit [N-1:0] pend;
        bit [N-1:0] syn;
        bit         hs;
        int         pick;
        int         j;
        if (rst) begin
            filt[g] = '0;
            rep[g]  = '0;
            mv[g]   = 1'b0;
            ml[g]   = 1'b0;
            ma[g]   = 0;
            ptr[g]  = 0;
            for (int k = 0; k < SS; k++) hist[g][k] = '0;
            for (int i = 0; i < N; i++) run[g][i] = 0;
        end else begin
            pend = (filt[g] ^ rep[g]) & ~msk;
            hs   = mv[g] && rdy;
            pick = -1;
            for (int k = 0; k < N; k++) begin
                j = (ptr[g] + k) % N;
                if (pick < 0 && pend[j] && !(hs && j == ma[g]))
                    pick = j;
            end
            if (hs) rep[g][ma[g]] = ml[g];
            if (!mv[g] || rdy) begin
                mv[g] = (pick >= 0);
                if (pick >= 0) begin
                    ma[g]  = pick;
                    ml[g]  = filt[g][pick];
                    ptr[g] = (pick + 1) % N;
                end
            end
            syn = hist[g][SS-1];
            for (int i = 0; i < N; i++) begin
                if (syn[i] != filt[g][i]) begin
                    run[g][i]++;
                    if (run[g][i] >= stab(g)) begin
                        filt[g][i] = syn[i];
                        run[g][i]  = 0;
                    end
                end else begin
                    run[g][i] = 0;
                end
            end
            for (int k = SS - 1; k > 0; k--) hist[g][k] = hist[g][k-1];
            hist[g][0] = irq;
        end
    endtask

    task automatic compare();
        bit busy_exp;
        for (int g = 0; g < 2; g++) begin
            busy_exp = (|((filt[g] ^ rep[g]) & ~msk)) | mv[g];
            chk("valid", g, 32'(dv[g]), 32'(mv[g]));
            chk("busy", g, 32'(db[g]), 32'(busy_exp));
            if (mv[g]) begin
                chk("addr", g, 32'(da[g]), ma[g]);
                chk("level", g, 32'(dl[g]), 32'(ml[g]));
            end
            if (dv[g] === 1'b1 && rdy === 1'b1)
                evq.push_back('{g, int'(da[g]), int'(dl[g]), cyc});
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        m_update(0);
        m_update(1);
        cyc++;
        #1;
    endtask

    function automatic int n_ev(input int g);
        int n = 0;
        foreach (evq[i]) if (evq[i].g == g) n++;
        return n;
    endfunction

    function automatic ev_t ev(input int g, input int k);
        ev_t e;
        int  n = 0;
        e = '{-1, -1, -1, -1};
        foreach (evq[i]) begin
            if (evq[i].g == g) begin
                if (n == k) e = evq[i];
                n++;
            end
        end
        return e;
    endfunction

    initial begin
        ev_t e;
        ev_t e0;
        int  c0;
        rst = 1'b1;
        irq = '0;
        msk = '0;
        rdy = 1'b1;
        step();
        step();
        chk("rst_valid", 0, 32'(dv[0]), 0);
        chk("rst_busy", 0, 32'(db[0]), 0);
        chk("rst_addr", 0, 32'(da[0]), 0);
        chk("rst_level", 0, 32'(dl[0]), 0);
        rst = 1'b0;

        // Lines 0 and 2 rise together
        evq.delete();
        irq = 16'h0005;
        repeat (12) step();
        chk("s1_count", 0, n_ev(0), 2);
        e0 = ev(0, 0);
        e  = ev(0, 1);
        chk("s1_a0", 0, e0.a, 0);
        chk("s1_l0", 0, e0.l, 1);
        chk("s1_a1", 0, e.a, 2);
        chk("s1_l1", 0, e.l, 1);
        chk("s1_b2b", 0, e.c - e0.c, 1);
        for (int g = 0; g < 2; g++) chk("s1_idle", g, 32'(db[g]), 0);
        irq = '0;
        repeat (15) step();

        // Short and long pulses on line 1
        evq.delete();
        irq = 16'h0002;
        repeat (3) step();
        irq = '0;
        repeat (15) step();
        chk("s2_short", 1, n_ev(1), 0);
        chk("s2_fast", 0, n_ev(0), 2);
        evq.delete();
        irq = 16'h0002;
        repeat (5) step();
        irq = '0;
        repeat (20) step();
        chk("s2_count", 1, n_ev(1), 2);
        e0 = ev(1, 0);
        e  = ev(1, 1);
        chk("s2_a0", 1, e0.a, 1);
        chk("s2_l0", 1, e0.l, 1);
        chk("s2_a1", 1, e.a, 1);
        chk("s2_l1", 1, e.l, 0);

        // Line 3 toggles while the sender stalls
        evq.delete();
        rdy = 1'b0;
        irq = 16'h0008;
        repeat (12) step();
        irq = '0;
        repeat (10) step();
        for (int g = 0; g < 2; g++) begin
            chk("s3_hold_v", g, 32'(dv[g]), 1);
            chk("s3_hold_a", g, 32'(da[g]), 3);
            chk("s3_hold_l", g, 32'(dl[g]), 1);
            chk("s3_none", g, n_ev(g), 0);
        end
        rdy = 1'b1;
        repeat (20) step();
        for (int g = 0; g < 2; g++) begin
            chk("s3_count", g, n_ev(g), 2);
            e0 = ev(g, 0);
            e  = ev(g, 1);
            chk("s3_m0", g, e0.a * 2 + e0.l, 7);
            chk("s3_m1", g, e.a * 2 + e.l, 6);
        end

        // Eight lines rise at once right after reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        evq.delete();
        irq = 16'h00FF;
        repeat (20) step();
        for (int g = 0; g < 2; g++) begin
            chk("s4_count", g, n_ev(g), 8);
            e0 = ev(g, 0);
            for (int k = 0; k < 8; k++) begin
                e = ev(g, k);
                chk("s4_addr", g, e.a, k);
                chk("s4_level", g, e.l, 1);
                chk("s4_b2b", g, e.c - e0.c, k);
            end
        end
        irq = '0;
        repeat (30) step();

        // Masked line stays silent until unmasked
        evq.delete();
        msk = 16'h0004;
        irq = 16'h0004;
        repeat (15) step();
        for (int g = 0; g < 2; g++) begin
            chk("s5_masked", g, n_ev(g), 0);
            chk("s5_idle", g, 32'(db[g]), 0);
        end
        msk = '0;
        c0  = cyc;
        repeat (10) step();
        for (int g = 0; g < 2; g++) begin
            chk("s5_count", g, n_ev(g), 1);
            e = ev(g, 0);
            chk("s5_addr", g, e.a, 2);
            chk("s5_level", g, e.l, 1);
            chk("s5_lat", g, 32'(e.c - c0 <= SS + stab(g) + 2), 1);
        end

        // Reset drops a held message; high lines are re-reported
        rdy = 1'b0;
        irq = 16'h0044;
        repeat (12) step();
        for (int g = 0; g < 2; g++) begin
            chk("s6_held", g, 32'(dv[g]), 1);
            chk("s6_addr", g, 32'(da[g]), 6);
        end
        rst = 1'b1;
        step();
        for (int g = 0; g < 2; g++) chk("s6_drop", g, 32'(dv[g]), 0);
        rst = 1'b0;
        rdy = 1'b1;
        evq.delete();
        repeat (20) step();
        for (int g = 0; g < 2; g++) begin
            chk("s6_count", g, n_ev(g), 2);
            e0 = ev(g, 0);
            e  = ev(g, 1);
            chk("s6_m0", g, e0.a * 2 + e0.l, 5);
            chk("s6_m1", g, e.a * 2 + e.l, 13);
        end

        // Random traffic
        repeat (800) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 15) == 0) irq[i] = ~irq[i];
            rdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 49) == 0)
                msk[$urandom_range(0, N - 1)] ^= 1'b1;
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        rdy = 1'b1;
        msk = '0;
        repeat (80) step();
        for (int g = 0; g < 2; g++) chk("drain_idle", g, 32'(db[g]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
